// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the 7-segment scan reader.
// Segment bit order is a..g from bit6 down to bit0; 1 means the segment is lit.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110010;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] DIG_UNITS = 2'b01;
  localparam logic [1:0] DIG_TENS  = 2'b10;

  typedef logic [3:0] digit_t;
  localparam digit_t DIGIT_BLANK   = 4'hA;
  localparam digit_t DIGIT_INVALID = 4'hF;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_t;

  typedef struct packed {
    logic       err;
    logic [7:0] value;
  } frame_t;

  // A blank tens digit is a suppressed leading zero; a blank units digit is an error.
  function automatic frame_t compose(input digit_t tens, input digit_t units);
    frame_t f;
    logic [7:0] t;
    f.err   = 1'b0;
    f.value = 8'd0;
    if (units == DIGIT_BLANK || units == DIGIT_INVALID || tens == DIGIT_INVALID) begin
      f.err = 1'b1;
    end else begin
      t       = (tens == DIGIT_BLANK) ? 8'd0 : {4'd0, tens};
      f.value = t * 8'd10 + {4'd0, units};
    end
    return f;
  endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational 7-segment pattern to digit-code decoder.
// Unknown patterns map to DIGIT_INVALID, all-off maps to DIGIT_BLANK.
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code
);

  always_comb begin
    // NOTE: every path assigns code (default branch included), so no latch is inferred.
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = DIGIT_BLANK;
      default:   code = DIGIT_INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a two-digit multiplexed 7-segment bus back into a 0..99 value.
// Each digit is captured once per steady run, then the frame is offered on valid/ready.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [1:0] dig_sel,
  output logic [7:0] out_value,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_ARM = SW'(STABLE_CYCLES - 1);

  logic [1:0]    prev_dig;
  logic [6:0]    prev_seg;
  logic [SW-1:0] stab;
  logic [SW-1:0] stab_nxt;

  digit_t units_r, tens_r, dig_code;
  logic   have_u, have_t;
  state_t state_q, state_d;
  logic   load, accept;
  frame_t frame_nxt;

  logic dig_on, same, capture, cap_u, cap_t;

  seg7_digit_dec u_dec (
    .seg  (seg_in),
    .code (dig_code)
  );

  assign dig_on  = (dig_sel == DIG_UNITS) || (dig_sel == DIG_TENS);
  assign same    = ({dig_sel, seg_in} == {prev_dig, prev_seg});
  // Firing only on the ARM->MAX step means a saturated run never re-captures.
  assign capture = dig_on && same && (stab == STAB_ARM);
  assign cap_u   = capture && (dig_sel == DIG_UNITS);
  assign cap_t   = capture && (dig_sel == DIG_TENS);

  always_comb begin
    stab_nxt = stab;
    if (!dig_on)               stab_nxt = '0;
    else if (!same)            stab_nxt = SW'(1);
    else if (stab != STAB_MAX) stab_nxt = stab + SW'(1);
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if ((have_u || cap_u) && (have_t || cap_t)) begin
          state_d = ST_EMIT;
          load    = 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_d = ST_COLLECT;
          accept  = 1'b1;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // The digit captured on the completing edge is not yet in its register.
  assign frame_nxt = compose(cap_t ? dig_code : tens_r, cap_u ? dig_code : units_r);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every register, digit storage included, is reset so a frame
  // interrupted by reset cannot leak stale digits into the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_dig  <= 2'b00;
      prev_seg  <= SEG_BLANK;
      stab      <= '0;
      units_r   <= DIGIT_BLANK;
      tens_r    <= DIGIT_BLANK;
      have_u    <= 1'b0;
      have_t    <= 1'b0;
      out_value <= 8'd0;
      out_err   <= 1'b0;
    end else begin
      prev_dig <= dig_sel;
      prev_seg <= seg_in;
      stab     <= stab_nxt;
      if (state_q == ST_COLLECT) begin
        if (cap_u) begin
          units_r <= dig_code;
          have_u  <= 1'b1;
        end
        if (cap_t) begin
          tens_r <= dig_code;
          have_t <= 1'b1;
        end
      end
      if (accept) begin
        have_u <= 1'b0;
        have_t <= 1'b0;
      end
      if (load) begin
        out_value <= frame_nxt.value;
        out_err   <= frame_nxt.err;
      end
    end
  end

  assign out_valid = (state_q == ST_EMIT);

endmodule
